// File: rtl/aib_deskew_cal_fsm.sv
// rtl/aib_deskew_cal_fsm.sv - AIB deskew code sweep calibration FSM; optional pass_map port via AIB_DESKEW_CAL_PASSMAP_EN
module aib_deskew_cal_fsm #(
  parameter int SETTLE_CYC = 8,
  parameter int WIN_CYC    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cal_start,
  input  logic        cal_abort,
  input  logic        chk_valid,
  input  logic        chk_pass,
  output logic        deskew_ovrd,
  output logic [3:0]  deskew_data,
  output logic        deskew_en,
  output logic        cal_busy,
  output logic        cal_done,
  output logic        cal_fail,
  output logic [3:0]  best_code
`ifdef AIB_DESKEW_CAL_PASSMAP_EN
  ,
  output logic [15:0] pass_map
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] WIN_LAST    = 8'(WIN_CYC - 1);

  state_t     state_q;
  logic [3:0] code_q;
  logic [7:0] cnt_q;

  // Window accumulators: any valid compare seen, any failing compare seen
  logic       seen_valid_q;
  logic       seen_bad_q;

  // Current pass run and best run found so far (length 0 = none)
  logic [3:0] cur_start_q;
  logic [4:0] cur_len_q;
  logic [3:0] best_start_q;
  logic [4:0] best_len_q;

  // Registered outputs
  logic       ovrd_q;
  logic [3:0] data_q;
  logic       en_q;
  logic       busy_q;
  logic       done_q;
  logic       fail_q;
  logic [3:0] best_code_q;

  logic       win_last_d;
  logic       verdict_d;
  logic [4:0] run_len_d;
  logic [3:0] run_start_d;
  logic       run_upd_d;
  logic [4:0] fin_len_d;
  logic [3:0] fin_start_d;
  logic [3:0] fin_code_d;
  logic       start_go_d;
  logic       eval_d;

  // Verdict of the current window (including this cycle) and the resulting run/best update
  always_comb begin
    win_last_d  = (cnt_q == WIN_LAST);
    verdict_d   = (seen_valid_q | chk_valid) & ~(seen_bad_q | (chk_valid & ~chk_pass));
    run_len_d   = verdict_d ? (cur_len_q + 5'd1) : 5'd0;
    run_start_d = (cur_len_q == 5'd0) ? code_q : cur_start_q;
    // Strictly longer only, so an equal-length later run never displaces an earlier one
    run_upd_d   = verdict_d && (run_len_d > best_len_q);
    fin_len_d   = run_upd_d ? run_len_d : best_len_q;
    fin_start_d = run_upd_d ? run_start_d : best_start_q;
    fin_code_d  = fin_start_d + 4'((fin_len_d - 5'd1) >> 1);
    start_go_d  = ~cal_abort & cal_start &
                  ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_FAIL));
    eval_d      = ~cal_abort & (state_q == S_SAMPLE) & win_last_d;
  end

  // Sweep state machine with registered outputs; abort behaves like a synchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      code_q       <= 4'd0;
      cnt_q        <= 8'd0;
      seen_valid_q <= 1'b0;
      seen_bad_q   <= 1'b0;
      cur_start_q  <= 4'd0;
      cur_len_q    <= 5'd0;
      best_start_q <= 4'd0;
      best_len_q   <= 5'd0;
      ovrd_q       <= 1'b0;
      data_q       <= 4'd0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      best_code_q  <= 4'd0;
    end else if (cal_abort) begin
      state_q      <= S_IDLE;
      code_q       <= 4'd0;
      cnt_q        <= 8'd0;
      seen_valid_q <= 1'b0;
      seen_bad_q   <= 1'b0;
      cur_start_q  <= 4'd0;
      cur_len_q    <= 5'd0;
      best_start_q <= 4'd0;
      best_len_q   <= 5'd0;
      ovrd_q       <= 1'b0;
      data_q       <= 4'd0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      best_code_q  <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (cal_start) begin
            state_q      <= S_SETTLE;
            code_q       <= 4'd0;
            cnt_q        <= 8'd0;
            seen_valid_q <= 1'b0;
            seen_bad_q   <= 1'b0;
            cur_start_q  <= 4'd0;
            cur_len_q    <= 5'd0;
            best_start_q <= 4'd0;
            best_len_q   <= 5'd0;
            ovrd_q       <= 1'b1;
            data_q       <= 4'd0;
            en_q         <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            best_code_q  <= 4'd0;
          end
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= S_SAMPLE;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
          end
        end
        S_SAMPLE: begin
          if (win_last_d) begin
            cnt_q        <= 8'd0;
            seen_valid_q <= 1'b0;
            seen_bad_q   <= 1'b0;
            cur_len_q    <= run_len_d;
            cur_start_q  <= run_start_d;
            best_len_q   <= fin_len_d;
            best_start_q <= fin_start_d;
            if (code_q != 4'd15) begin
              state_q <= S_SETTLE;
              code_q  <= code_q + 4'd1;
              data_q  <= code_q + 4'd1;
            end else if (fin_len_d != 5'd0) begin
              state_q     <= S_DONE;
              ovrd_q      <= 1'b1;
              data_q      <= fin_code_d;
              en_q        <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              fail_q      <= 1'b0;
              best_code_q <= fin_code_d;
            end else begin
              state_q     <= S_FAIL;
              ovrd_q      <= 1'b0;
              data_q      <= 4'd0;
              en_q        <= 1'b1;
              busy_q      <= 1'b0;
              done_q      <= 1'b0;
              fail_q      <= 1'b1;
              best_code_q <= 4'd0;
            end
          end else begin
            cnt_q        <= cnt_q + 8'd1;
            seen_valid_q <= seen_valid_q | chk_valid;
            seen_bad_q   <= seen_bad_q | (chk_valid & ~chk_pass);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign deskew_ovrd = ovrd_q;
  assign deskew_data = data_q;
  assign deskew_en   = en_q;
  assign cal_busy    = busy_q;
  assign cal_done    = done_q;
  assign cal_fail    = fail_q;
  assign best_code   = best_code_q;

`ifdef AIB_DESKEW_CAL_PASSMAP_EN
  logic [15:0] pass_map_q;

  // Per-code verdict bitmap; cleared on start/abort, held through DONE and FAIL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_map_q <= 16'h0000;
    end else if (cal_abort || start_go_d) begin
      pass_map_q <= 16'h0000;
    end else if (eval_d) begin
      pass_map_q[code_q] <= verdict_d;
    end
  end

  assign pass_map = pass_map_q;
`else
  logic unused_d;
  assign unused_d = start_go_d ^ eval_d;
`endif

endmodule

// File: tb/tb_aib_deskew_cal_fsm.sv
// tb/tb_aib_deskew_cal_fsm.sv - randomized self-checking bench for aib_deskew_cal_fsm
`timescale 1ns/1ps
module tb_aib_deskew_cal_fsm;
  localparam int SC    = 8;
  localparam int WC    = 16;
  localparam int CPC   = SC + WC;
  localparam int SWEEP = 16 * CPC;

  logic        clk = 1'b0;
  logic        rst;
  logic        cal_start;
  logic        cal_abort;
  logic        chk_valid;
  logic        chk_pass;
  logic        deskew_ovrd;
  logic [3:0]  deskew_data;
  logic        deskew_en;
  logic        cal_busy;
  logic        cal_done;
  logic        cal_fail;
  logic [3:0]  best_code;
`ifdef AIB_DESKEW_CAL_PASSMAP_EN
  logic [15:0] pass_map;
`endif
  logic [12:0] outs;

  int checks = 0;
  int errors = 0;

  bit stim_v [SWEEP];
  bit stim_p [SWEEP];

  assign outs = {deskew_ovrd, deskew_data, deskew_en, cal_busy, cal_done, cal_fail, best_code};

  always #5 clk = ~clk;

  aib_deskew_cal_fsm #(.SETTLE_CYC(SC), .WIN_CYC(WC)) dut (
    .clk         (clk),
    .rst         (rst),
    .cal_start   (cal_start),
    .cal_abort   (cal_abort),
    .chk_valid   (chk_valid),
    .chk_pass    (chk_pass),
    .deskew_ovrd (deskew_ovrd),
    .deskew_data (deskew_data),
    .deskew_en   (deskew_en),
    .cal_busy    (cal_busy),
    .cal_done    (cal_done),
    .cal_fail    (cal_fail),
    .best_code   (best_code)
`ifdef AIB_DESKEW_CAL_PASSMAP_EN
    ,
    .pass_map    (pass_map)
`endif
  );

  // Reference: a code passes if its sample window had a valid compare and no valid failing compare
  function automatic logic [15:0] model_verdicts();
    logic [15:0] m;
    bit any;
    bit bad;
    int idx;
    m = '0;
    for (int k = 0; k < 16; k++) begin
      any = 0;
      bad = 0;
      for (int j = 0; j < WC; j++) begin
        idx = k * CPC + SC + j;
        if (stim_v[idx]) begin
          any = 1;
          if (!stim_p[idx]) bad = 1;
        end
      end
      m[k] = any && !bad;
    end
    return m;
  endfunction

  // Reference: search longest length first, lowest start first; -1 when nothing passed
  function automatic int model_best(input logic [15:0] m);
    int  res;
    bit  all_ok;
    res = -1;
    for (int len = 16; len >= 1; len--) begin
      for (int s = 0; s + len <= 16; s++) begin
        all_ok = 1;
        for (int i = s; i < s + len; i++) if (!m[i]) all_ok = 0;
        if (all_ok && res < 0) res = s + (len - 1) / 2;
      end
    end
    return res;
  endfunction

  task automatic gen_stim(input logic [15:0] tgt, input bit never_valid);
    int base;
    int j;
    for (int c = 0; c < SWEEP; c++) begin
      stim_v[c] = never_valid ? 1'b0 : 1'($urandom_range(0, 1));
      stim_p[c] = 1'($urandom_range(0, 1));
    end
    if (!never_valid) begin
      for (int k = 0; k < 16; k++) begin
        base = k * CPC + SC;
        j = $urandom_range(0, WC - 1);
        if (tgt[k]) begin
          for (int i = 0; i < WC; i++) stim_p[base + i] = 1'b1;
          stim_v[base + j] = 1'b1;
        end else begin
          stim_v[base + j] = 1'b1;
          stim_p[base + j] = 1'b0;
        end
      end
    end
  endtask

  task automatic sweep_prefix(input int ncyc);
    @(negedge clk);
    cal_start = 1'b1; chk_valid = 1'b0; chk_pass = 1'b0;
    @(negedge clk);
    cal_start = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      chk_valid = stim_v[c];
      chk_pass  = stim_p[c];
      @(negedge clk);
    end
  endtask

  task automatic run_sweep(input string name, input bit exp_done, input logic [3:0] exp_best,
                           input int poke_at, input logic [15:0] exp_map);
    int          bad_cyc;
    logic [12:0] bad_outs;
    logic [3:0]  exp_code;
    bad_cyc  = -1;
    bad_outs = '0;
    @(negedge clk);
    cal_start = 1'b1; chk_valid = 1'b0; chk_pass = 1'b0;
    @(negedge clk);
    cal_start = 1'b0;
    for (int c = 0; c < SWEEP; c++) begin
      chk_valid = stim_v[c];
      chk_pass  = stim_p[c];
      cal_start = (c == poke_at);
      exp_code  = 4'(c / CPC);
      if (bad_cyc < 0 && (cal_busy !== 1'b1 || deskew_ovrd !== 1'b1 || deskew_en !== 1'b0 ||
                          deskew_data !== exp_code || cal_done !== 1'b0 || cal_fail !== 1'b0)) begin
        bad_cyc  = c;
        bad_outs = outs;
      end
      @(negedge clk);
    end
    cal_start = 1'b0; chk_valid = 1'b0; chk_pass = 1'b0;
    checks++;
    if (bad_cyc >= 0) begin
      errors++;
      $display("FAIL %s_trace: sweep cycle %0d outs(ovrd,data,en,busy,done,fail,best)=%b want busy=1 ovrd=1 data=%0d", name, bad_cyc, bad_outs, bad_cyc / CPC);
    end
    checks++;
    if (cal_done !== exp_done || cal_fail !== !exp_done || cal_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_status: done=%b fail=%b busy=%b want done=%b fail=%b busy=0", name, cal_done, cal_fail, cal_busy, exp_done, !exp_done);
    end
    if (exp_done) begin
      checks++;
      if (best_code !== exp_best || deskew_data !== exp_best || deskew_ovrd !== 1'b1 || deskew_en !== 1'b0) begin
        errors++;
        $display("FAIL %s_best: best=%0d data=%0d ovrd=%b en=%b want best=data=%0d ovrd=1 en=0", name, best_code, deskew_data, deskew_ovrd, deskew_en, exp_best);
      end
    end else begin
      checks++;
      if (deskew_ovrd !== 1'b0 || deskew_en !== 1'b1 || deskew_data !== 4'd0) begin
        errors++;
        $display("FAIL %s_fallback: ovrd=%b en=%b data=%0d want ovrd=0 en=1 data=0", name, deskew_ovrd, deskew_en, deskew_data);
      end
    end
`ifdef AIB_DESKEW_CAL_PASSMAP_EN
    checks++;
    if (pass_map !== exp_map) begin
      errors++;
      $display("FAIL %s_pass_map: got %h want %h", name, pass_map, exp_map);
    end
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (cal_done !== exp_done || cal_fail !== !exp_done) begin
      errors++;
      $display("FAIL %s_hold: done=%b fail=%b want done=%b fail=%b", name, cal_done, cal_fail, exp_done, !exp_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cal_start = 1'b0; cal_abort = 1'b0; chk_valid = 1'b0; chk_pass = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", outs);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk_valid = 1'($urandom_range(0, 1));
      chk_pass  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk_valid = 1'b0; chk_pass = 1'b0;
    checks++;
    if (outs !== 13'h0) begin
      errors++;
      $display("FAIL reset_idle_hold: got %b want 0", outs);
    end
  endtask

  task automatic test_center_run();
    gen_stim(16'h07F8, 0);
    run_sweep("center_3_10", 1'b1, 4'd6, -1, 16'h07F8);
  endtask

  task automatic test_two_runs();
    gen_stim(16'hF006, 0);
    run_sweep("runs_1_2_12_15", 1'b1, 4'd13, -1, 16'hF006);
  endtask

  task automatic test_tie();
    gen_stim(16'h0E1C, 0);
    run_sweep("tie_2_4_9_11", 1'b1, 4'd3, -1, 16'h0E1C);
  endtask

  task automatic test_no_valid();
    gen_stim(16'h0000, 1);
    run_sweep("no_valid", 1'b0, 4'd0, -1, 16'h0000);
  endtask

  task automatic test_last_cycle_fail();
    for (int c = 0; c < SWEEP; c++) begin
      stim_v[c] = 1'b1;
      stim_p[c] = 1'b1;
    end
    stim_p[15 * CPC + SC + WC - 1] = 1'b0;
    run_sweep("last_cycle_fail", 1'b1, 4'd7, -1, 16'h7FFF);
  endtask

  task automatic test_busy_start();
    logic [15:0] m;
    int          b;
    gen_stim(16'($urandom), 0);
    m = model_verdicts();
    b = model_best(m);
    run_sweep("busy_start", b >= 0, 4'(b < 0 ? 0 : b), $urandom_range(1, SWEEP - 2), m);
  endtask

  task automatic test_abort();
    logic [15:0] m;
    int          b;
    int          n;
    gen_stim(16'($urandom), 0);
    n = 7 * CPC + SC + 5;
    sweep_prefix(n);
    checks++;
    if (cal_busy !== 1'b1 || deskew_data !== 4'd7) begin
      errors++;
      $display("FAIL abort_precond: busy=%b data=%0d want busy=1 data=7", cal_busy, deskew_data);
    end
    chk_valid = stim_v[n]; chk_pass = stim_p[n];
    cal_abort = 1'b1;
    @(negedge clk);
    cal_abort = 1'b0; chk_valid = 1'b0; chk_pass = 1'b0;
    checks++;
    if (outs !== 13'h0) begin
      errors++;
      $display("FAIL abort_outputs: got %b want 0", outs);
    end
`ifdef AIB_DESKEW_CAL_PASSMAP_EN
    checks++;
    if (pass_map !== 16'h0) begin
      errors++;
      $display("FAIL abort_pass_map: got %h want 0000", pass_map);
    end
`endif
    gen_stim(16'($urandom), 0);
    m = model_verdicts();
    b = model_best(m);
    run_sweep("after_abort", b >= 0, 4'(b < 0 ? 0 : b), -1, m);
  endtask

  task automatic test_abort_priority();
    @(negedge clk);
    cal_start = 1'b1; cal_abort = 1'b1;
    @(negedge clk);
    cal_start = 1'b0; cal_abort = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== 13'h0) begin
      errors++;
      $display("FAIL abort_priority: got %b want 0", outs);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] m;
    int          b;
    gen_stim(16'($urandom), 0);
    sweep_prefix(4 * CPC + 3);
    checks++;
    if (cal_busy !== 1'b1 || deskew_data !== 4'd4) begin
      errors++;
      $display("FAIL areset_precond: busy=%b data=%0d want busy=1 data=4", cal_busy, deskew_data);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== 13'h0) begin
      errors++;
      $display("FAIL areset_immediate: got %b want 0", outs);
    end
    @(negedge clk);
    rst = 1'b0; chk_valid = 1'b0; chk_pass = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== 13'h0) begin
      errors++;
      $display("FAIL areset_idle: got %b want 0", outs);
    end
    gen_stim(16'($urandom), 0);
    m = model_verdicts();
    b = model_best(m);
    run_sweep("after_areset", b >= 0, 4'(b < 0 ? 0 : b), -1, m);
  endtask

  task automatic test_random();
    logic [15:0] m;
    int          b;
    for (int it = 0; it < 4; it++) begin
      gen_stim(16'($urandom) & 16'($urandom), 0);
      m = model_verdicts();
      b = model_best(m);
      run_sweep($sformatf("random%0d", it), b >= 0, 4'(b < 0 ? 0 : b), -1, m);
    end
  endtask

  initial begin
    test_reset();
    test_center_run();
    test_two_runs();
    test_tie();
    test_no_valid();
    test_last_cycle_fail();
    test_busy_start();
    test_abort();
    test_abort_priority();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
